// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 2-D pooling engine.
// Mode codes, FSM encodings, clog2 and output-geometry helpers.
package pool_pkg;

    typedef enum logic [1:0] {
        MODE_MAX = 2'd0,
        MODE_MIN = 2'd1,
        MODE_AVG = 2'd2,
        MODE_SUM = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Never returns 0 so every derived bus is at least one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Partial windows at the right/bottom edges are dropped.
    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    // 16-bit fixed-point reciprocal of K*K; the +1 makes the
    // product floor to the exact quotient for in-range sums.
    function automatic int recip(input int k);
        return 65536 / (k * k) + 1;
    endfunction

endpackage

// File: rtl/pool_out_bram.sv
// Output result buffer: 1 write / 1 read synchronous RAM.
// Ports: we/waddr/wdata (FSM side), raddr -> rdata 1-cycle (inference side).
module pool_out_bram
    import pool_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 9,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Out-of-range reads return 0 rather than an undefined word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if ({1'b0, raddr} < (AW + 1)'(DEPTH)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/pool2d_engine.sv
// KxK / STRIDE pooling engine over a channel-planar image in external RAM.
// Ports: start/mode in, src_* RAM read port, infer_* result read port, busy/done/curr_state.
module pool2d_engine
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 7,
    parameter int IMG_H  = 7,
    parameter int CH     = 1,
    parameter int K      = 3,
    parameter int STRIDE = 2,
    parameter int RD_LAT = 2,
    localparam int SAW   = clog2(CH * IMG_H * IMG_W),
    localparam int OAW   = clog2(CH * out_dim(IMG_H, K, STRIDE)
                                    * out_dim(IMG_W, K, STRIDE))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              src_rd_en,
    output logic [SAW-1:0]    src_addr,
    input  logic [DATA_W-1:0] src_rdata,
    input  logic [OAW-1:0]    infer_addr,
    output logic [DATA_W-1:0] infer_dout,
    output logic              busy,
    output logic              done,
    output logic [2:0]        curr_state
);

    localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
    localparam int DEPTH = CH * OUT_H * OUT_W;
    localparam int SUMW  = DATA_W + clog2(K * K);
    localparam int PW    = SUMW + 17;
    localparam int RECIP = recip(K);

    localparam logic [15:0] KM1  = 16'(K - 1);
    localparam logic [15:0] OWM1 = 16'(OUT_W - 1);
    localparam logic [15:0] OHM1 = 16'(OUT_H - 1);
    localparam logic [15:0] CHM1 = 16'(CH - 1);
    localparam logic [15:0] DLM1 = 16'(RD_LAT - 1);
    localparam logic [SUMW-1:0] SAT = SUMW'((1 << DATA_W) - 1);

    state_e state, nstate;
    mode_e  mode_q;

    logic [15:0] i_q, j_q, ox_q, oy_q, c_q, d_q;
    logic [RD_LAT-1:0] vpipe, fpipe;
    logic [SUMW-1:0] acc, din;
    logic [PW-1:0] prod;
    logic [DATA_W-1:0] result, bram_q;
    logic [OAW-1:0] waddr;
    logic go, elem_last, drain_last, last_win, fetch, wr;

    assign fetch      = (state == S_FETCH);
    assign wr         = (state == S_WRITE);
    assign go         = start && (state == S_IDLE || state == S_DONE);
    assign elem_last  = (i_q == KM1) && (j_q == KM1);
    assign drain_last = (d_q == DLM1);
    assign last_win   = (ox_q == OWM1) && (oy_q == OHM1) && (c_q == CHM1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) nstate = S_FETCH;
            S_FETCH: if (elem_last) nstate = S_DRAIN;
            S_DRAIN: if (drain_last) nstate = S_WRITE;
            S_WRITE: nstate = last_win ? S_DONE : S_FETCH;
            default: nstate = S_IDLE;
        endcase
    end

    // Window (i,j), drain (d) and output (ox,oy,c) counters.
    // All wrap to 0 so IDLE and DONE always hold a clean origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_MAX;
            i_q    <= '0;
            j_q    <= '0;
            d_q    <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            c_q    <= '0;
        end else begin
            if (go) mode_q <= mode_e'(mode);
            if (fetch) begin
                if (i_q == KM1) begin
                    i_q <= '0;
                    j_q <= (j_q == KM1) ? '0 : j_q + 16'd1;
                end else begin
                    i_q <= i_q + 16'd1;
                end
            end
            if (state == S_DRAIN) d_q <= d_q + 16'd1;
            if (wr) begin
                d_q <= '0;
                if (ox_q != OWM1) begin
                    ox_q <= ox_q + 16'd1;
                end else begin
                    ox_q <= '0;
                    if (oy_q != OHM1) begin
                        oy_q <= oy_q + 16'd1;
                    end else begin
                        oy_q <= '0;
                        c_q  <= (c_q == CHM1) ? '0 : c_q + 16'd1;
                    end
                end
            end
        end
    end

    assign src_rd_en = fetch;
    assign src_addr  = fetch ?
        SAW'(c_q) * SAW'(IMG_H * IMG_W)
        + (SAW'(oy_q) * SAW'(STRIDE) + SAW'(j_q)) * SAW'(IMG_W)
        + SAW'(ox_q) * SAW'(STRIDE) + SAW'(i_q) : '0;

    // fpipe marks the first element so the reducer reseeds per window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            fpipe <= '0;
        end else begin
            vpipe[0] <= fetch;
            fpipe[0] <= fetch && (i_q == '0) && (j_q == '0);
            for (int k = 1; k < RD_LAT; k++) begin
                vpipe[k] <= vpipe[k-1];
                fpipe[k] <= fpipe[k-1];
            end
        end
    end

    assign din = {{(SUMW - DATA_W){1'b0}}, src_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (vpipe[RD_LAT-1]) begin
            if (fpipe[RD_LAT-1]) begin
                acc <= din;
            end else begin
                unique case (mode_q)
                    MODE_MAX: if (din > acc) acc <= din;
                    MODE_MIN: if (din < acc) acc <= din;
                    default:  acc <= acc + din;
                endcase
            end
        end
    end

    always_comb begin
        prod   = PW'(acc) * PW'(RECIP);
        result = acc[DATA_W-1:0];
        if (mode_q == MODE_AVG) begin
            result = DATA_W'(prod >> 16);
        end else if (mode_q == MODE_SUM && acc > SAT) begin
            result = '1;
        end
    end

    assign waddr = OAW'(c_q) * OAW'(OUT_H * OUT_W)
                 + OAW'(oy_q) * OAW'(OUT_W) + OAW'(ox_q);

    pool_out_bram #(
        .DW   (DATA_W),
        .DEPTH(DEPTH),
        .AW   (OAW)
    ) u_obuf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr),
        .waddr(waddr),
        .wdata(result),
        .raddr(infer_addr),
        .rdata(bram_q)
    );

    assign busy       = fetch || (state == S_DRAIN) || wr;
    assign done       = (state == S_DONE);
    assign infer_dout = done ? bram_q : '0;
    assign curr_state = state;

endmodule

// File: tb/tb_pool2d_engine.sv
// Scoreboard bench for pool2d_engine: three configurations with RAM models.
// Expected windows are queued at start and compared on buffer readout.
module tb_pool2d_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_s [3];
    logic [1:0] mode_s  [3];
    logic [4:0] ia      [3];
    logic       en_s    [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic [7:0] dout_s  [3];
    logic [2:0] cs_s    [3];

    logic [5:0] a_addr;
    logic [6:0] b_addr;
    logic [5:0] c_addr;
    logic [7:0] a_rd, b_rd, c_rd;

    logic [7:0] mem [3][128];
    logic [7:0] rp0 [3];
    logic [7:0] rp1 [3];
    logic [7:0] rp2 [3];

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got [64];
    int prev [64];

    pool2d_engine u_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode(mode_s[0]),
        .src_rd_en(en_s[0]), .src_addr(a_addr), .src_rdata(a_rd),
        .infer_addr(ia[0][3:0]), .infer_dout(dout_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .curr_state(cs_s[0])
    );

    pool2d_engine #(.CH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode(mode_s[1]),
        .src_rd_en(en_s[1]), .src_addr(b_addr), .src_rdata(b_rd),
        .infer_addr(ia[1]), .infer_dout(dout_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .curr_state(cs_s[1])
    );

    pool2d_engine #(.IMG_W(8), .RD_LAT(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .mode(mode_s[2]),
        .src_rd_en(en_s[2]), .src_addr(c_addr), .src_rdata(c_rd),
        .infer_addr(ia[2][3:0]), .infer_dout(dout_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .curr_state(cs_s[2])
    );

    // Source RAMs: data only for strobed reads, garbage otherwise.
    always @(posedge clk) begin
        rp0[0] <= en_s[0] ? mem[0][a_addr] : 8'hEE;
        rp0[1] <= rp0[0];
        rp0[2] <= rp0[1];
        rp1[0] <= en_s[1] ? mem[1][b_addr] : 8'hEE;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
        rp2[0] <= en_s[2] ? mem[2][c_addr] : 8'hEE;
        rp2[1] <= rp2[0];
        rp2[2] <= rp2[1];
    end
    assign a_rd = rp0[1];
    assign b_rd = rp1[1];
    assign c_rd = rp2[2];

    // Read-strobe monitor for the 8-wide, RD_LAT=3 instance.
    int rdcnt = 0, badcol = 0, blen = 0, bbad = 0, gap = 100, gbad = 0;
    always @(posedge clk) begin
        if (en_s[2]) begin
            rdcnt <= rdcnt + 1;
            if (c_addr[2:0] == 3'd7) badcol <= badcol + 1;
            if (blen == 0 && gap < 50 && gap != 4) gbad <= gbad + 1;
            blen <= blen + 1;
            gap  <= 0;
        end else begin
            if (blen != 0 && blen != 9) bbad <= bbad + 1;
            blen <= 0;
            if (gap < 1000) gap <= gap + 1;
        end
    end

    task automatic chk(input string tag, input int got_v, input int exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    function automatic int model(input int n, input int w, input int h,
                                 input int md, input int c,
                                 input int oy, input int ox);
        int sum, mx, mn, v;
        sum = 0;
        mx  = 0;
        mn  = 1000;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                v = int'(mem[n][c*h*w + (oy*2+j)*w + ox*2 + i]);
                sum += v;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
        end
        case (md)
            0: return mx;
            1: return mn;
            2: return sum / 9;
            default: return (sum > 255) ? 255 : sum;
        endcase
    endfunction

    task automatic readout(input int n, input int depth, input string tag);
        for (int a = 0; a < depth; a++) begin
            @(negedge clk);
            ia[n] = 5'(a);
            @(negedge clk);
            got[a] = int'(dout_s[n]);
            if (exp_q.size() == 0) chk({tag, "_qempty"}, 0, 1);
            else chk(tag, got[a], exp_q.pop_front());
        end
        @(negedge clk);
        ia[n] = 5'(depth);
        @(negedge clk);
        chk({tag, "_oob"}, int'(dout_s[n]), 0);
    endtask

    task automatic run(input int n, input int md, input int w, input int h,
                       input int ch, input int pulse_at, input string tag);
        int oh, ow, lat, cyc, want;
        oh  = (h - 3) / 2 + 1;
        ow  = (w - 3) / 2 + 1;
        lat = (n == 2) ? 3 : 2;
        want = ch * oh * ow * (9 + lat + 1);
        for (int c = 0; c < ch; c++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    exp_q.push_back(model(n, w, h, md, c, oy, ox));
        @(negedge clk);
        mode_s[n]  = 2'(md);
        start_s[n] = 1'b1;
        @(negedge clk);
        start_s[n] = 1'b0;
        chk({tag, "_busy"}, int'(busy_s[n]), 1);
        chk({tag, "_done_low"}, int'(done_s[n]), 0);
        cyc = 0;
        while (!done_s[n] && cyc < 2000) begin
            if (cyc == pulse_at) begin
                start_s[n] = 1'b1;
                mode_s[n]  = ~mode_s[n];
            end
            @(negedge clk);
            start_s[n] = 1'b0;
            cyc++;
        end
        chk({tag, "_done"}, int'(done_s[n]), 1);
        chk({tag, "_cycles"}, int'(cyc >= want - 2 && cyc <= want + 2), 1);
        readout(n, ch * oh * ow, tag);
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            start_s[n] = 1'b0;
            mode_s[n]  = 2'd0;
            ia[n]      = '0;
        end
        for (int a = 0; a < 128; a++) begin
            mem[0][a] = 8'(a);
            mem[1][a] = (a < 49) ? 8'(a) : 8'(a - 49 + 100);
            mem[2][a] = 8'(a);
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_s[0]), 0);
        chk("rst_done", int'(done_s[0]), 0);
        chk("rst_en", int'(en_s[0]), 0);
        chk("rst_state", int'(cs_s[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_dout", int'(dout_s[0]), 0);

        run(0, 0, 7, 7, 1, -1, "max");
        chk("max0", got[0], 16);
        chk("max4", got[4], 32);
        chk("max8", got[8], 48);
        run(0, 1, 7, 7, 1, -1, "min");
        chk("min0", got[0], 0);
        chk("min8", got[8], 32);
        run(0, 2, 7, 7, 1, -1, "avg");
        chk("avg0", got[0], 8);
        chk("avg8", got[8], 40);
        run(0, 3, 7, 7, 1, -1, "sum");
        chk("sum0", got[0], 72);
        chk("sum8", got[8], 255);

        @(negedge clk);
        start_s[0] = 1'b1;
        mode_s[0]  = 2'd0;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_en", int'(en_s[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy_s[0]), 0);
        chk("arst_done", int'(done_s[0]), 0);
        chk("arst_en", int'(en_s[0]), 0);
        chk("arst_state", int'(cs_s[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 0, 7, 7, 1, 5, "ign");
        for (int a = 0; a < 9; a++) prev[a] = got[a];
        run(0, 0, 7, 7, 1, -1, "rerun");
        for (int a = 0; a < 9; a++) chk("rerun_same", got[a], prev[a]);

        for (int a = 0; a < 49; a++) mem[0][a] = 8'hFF;
        run(0, 3, 7, 7, 1, -1, "sat");
        chk("sat4", got[4], 255);
        run(0, 2, 7, 7, 1, -1, "avg255");

        run(1, 0, 7, 7, 2, -1, "ch2");
        chk("ch2_0", got[0], 16);
        chk("ch2_9", got[9], 116);
        chk("ch2_17", got[17], 148);

        begin
            int r0, b0, bb0, g0;
            r0  = rdcnt;
            b0  = badcol;
            bb0 = bbad;
            g0  = gbad;
            run(2, 0, 8, 7, 1, -1, "w8");
            chk("w8_reads", rdcnt - r0, 81);
            chk("w8_col7", badcol - b0, 0);
            chk("w8_burst", bbad - bb0, 0);
            chk("w8_gap", gbad - g0, 0);
            chk("w8_out0", got[0], 18);
        end

        if (exp_q.size() != 0) chk("q_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
